apb_stream_sink: RTL and testbench

APB completer that receives the write stream from `apb_master` and turns it back into a valid/ready data stream. Each accepted write to the DATA register is pushed into an internal FIFO, and the FIFO head is presented on a streaming output for a downstream consumer. When the FIFO is full the block applies back-pressure on the bus by holding `pready` low. If the back-pressure lasts too long, the write is dropped and flagged with `pslverr`. Status and a drop counter are readable over APB.

---
 rtl/apb_stream_sink_if.sv | 33 +++
 rtl/apb_stream_sink.sv | 207 ++++++++++++++++++++
 tb/tb_apb_stream_sink.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_stream_sink_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | apb_stream_sink_if                                                    |
// | APB completer bus plus valid/ready stream output bundle.              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface apb_stream_sink_if #(
  parameter int DATA_WIDTH = 17,
  parameter int ADDR_WIDTH = 4
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, m_ready,
    input  prdata, pready, pslverr, m_valid, m_data
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, m_ready,
    output prdata, pready, pslverr, m_valid, m_data
  );
endinterface
`default_nettype wire

// File: rtl/apb_stream_sink.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | apb_stream_sink                                                       |
// | APB writes to DATA feed a FIFO drained as a valid/ready stream.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module apb_stream_sink #(
  parameter int DATA_WIDTH = 17,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 15,
  parameter int WAIT_LIMIT = 16
) (
  input logic              pclk,
  input logic              prst,
  apb_stream_sink_if.slave bus
);

  localparam int c_CW = $clog2(FIFO_DEPTH + 1);
  localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_WW = $clog2(WAIT_LIMIT + 1);

  localparam logic [c_CW-1:0]       c_DEPTH       = c_CW'(FIFO_DEPTH);
  localparam logic [c_PW-1:0]       c_PTR_LAST    = c_PW'(FIFO_DEPTH - 1);
  localparam logic [c_WW-1:0]       c_WAIT_LAST   = c_WW'(WAIT_LIMIT - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_DATA   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_STATUS = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_DROPS  = ADDR_WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [c_WW-1:0]       r_wait_cnt;
  logic                  r_push_pend;
  logic                  r_clr_pend;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_drops;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]       r_wr_ptr;
  logic [c_PW-1:0]       r_rd_ptr;
  logic [c_CW-1:0]       r_count;

  state_t                w_state_next;
  logic                  w_pready_next;
  logic                  w_pslverr_next;
  logic [DATA_WIDTH-1:0] w_prdata_next;
  logic [c_WW-1:0]       w_wait_next;
  logic                  w_push_pend_next;
  logic                  w_clr_pend_next;
  logic                  w_drop_inc;
  logic                  w_latch;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drops_clr;
  logic [c_CW-1:0]       w_count_next;
  logic                  w_full_next;
  logic [DATA_WIDTH-1:0] w_status;

  assign w_push      = (r_state == S_ACCESS) && r_push_pend;
  assign w_drops_clr = (r_state == S_ACCESS) && r_clr_pend;
  assign w_pop       = (r_count != '0) && bus.m_ready;

  // Occupancy after the current edge; every full/STATUS decision uses it.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_CW'(1);
    end
  end

  assign w_full_next = (w_count_next == c_DEPTH);

  always_comb begin
    w_status            = '0;
    w_status[c_CW+1:2]  = w_count_next;
    w_status[1]         = w_full_next;
    w_status[0]         = (w_count_next == '0);
  end

  always_comb begin
    w_state_next     = r_state;
    w_pready_next    = 1'b0;
    w_pslverr_next   = 1'b0;
    w_prdata_next    = '0;
    w_wait_next      = r_wait_cnt;
    w_push_pend_next = r_push_pend;
    w_clr_pend_next  = r_clr_pend;
    w_drop_inc       = 1'b0;
    w_latch          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_push_pend_next = 1'b0;
        w_clr_pend_next  = 1'b0;
        if (bus.psel && !bus.penable) begin
          w_latch = 1'b1;
          if (bus.pwrite && (bus.paddr == c_ADDR_DATA)) begin
            if (w_full_next) begin
              w_state_next = S_WAIT;
              w_wait_next  = '0;
            end else begin
              w_state_next     = S_ACCESS;
              w_pready_next    = 1'b1;
              w_push_pend_next = 1'b1;
            end
          end else begin
            w_state_next  = S_ACCESS;
            w_pready_next = 1'b1;
            if (bus.pwrite && (bus.paddr == c_ADDR_DROPS)) begin
              w_clr_pend_next = 1'b1;
            end else if (!bus.pwrite && (bus.paddr == c_ADDR_STATUS)) begin
              w_prdata_next = w_status;
            end else if (!bus.pwrite && (bus.paddr == c_ADDR_DROPS)) begin
              w_prdata_next = r_drops;
            end else begin
              w_pslverr_next = 1'b1;
            end
          end
        end
      end
      S_ACCESS: begin
        w_state_next     = S_IDLE;
        w_push_pend_next = 1'b0;
        w_clr_pend_next  = 1'b0;
      end
      S_WAIT: begin
        w_wait_next = r_wait_cnt + c_WW'(1);
        if (!bus.psel) begin
          w_state_next = S_IDLE;
        end else if (!w_full_next) begin
          w_state_next     = S_ACCESS;
          w_pready_next    = 1'b1;
          w_push_pend_next = 1'b1;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_state_next   = S_ACCESS;
          w_pready_next  = 1'b1;
          w_pslverr_next = 1'b1;
          w_drop_inc     = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_state     <= S_IDLE;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
      r_prdata    <= '0;
      r_wait_cnt  <= '0;
      r_push_pend <= 1'b0;
      r_clr_pend  <= 1'b0;
      r_drops     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pready    <= w_pready_next;
      r_pslverr   <= w_pslverr_next;
      r_prdata    <= w_prdata_next;
      r_wait_cnt  <= w_wait_next;
      r_push_pend <= w_push_pend_next;
      r_clr_pend  <= w_clr_pend_next;
      r_count     <= w_count_next;
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PW'(1);
      end
      if (w_drops_clr) begin
        r_drops <= '0;
      end else if (w_drop_inc && (r_drops != '1)) begin
        r_drops <= r_drops + DATA_WIDTH'(1);
      end
    end
  end

  // Storage and the setup-phase data latch carry no reset.
  always_ff @(posedge pclk) begin
    if (w_latch) begin
      r_wdata <= bus.pwdata;
    end
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_wdata;
    end
  end

  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;
  assign bus.prdata  = r_prdata;
  assign bus.m_valid = (r_count != '0);
  assign bus.m_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_stream_sink.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_apb_stream_sink                                                    |
// | Self-checking bench with a queue-based model of the stream sink.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_apb_stream_sink;
  localparam int DW    = 17;
  localparam int AW    = 4;
  localparam int DEPTH = 15;
  localparam int WLIM  = 16;
  localparam int TMO   = 200;

  logic pclk = 1'b0;
  logic prst = 1'b1;
  always #5 pclk = ~pclk;

  apb_stream_sink_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic ready_tb = 1'b0;
  logic rand_en  = 1'b0;
  logic rand_bit = 1'b0;
  assign bus.m_ready = rand_en ? rand_bit : ready_tb;
  always @(posedge pclk) rand_bit <= 1'($urandom_range(0, 1));

  apb_stream_sink #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .WAIT_LIMIT(WLIM)
  ) dut (
    .pclk(pclk),
    .prst(prst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  int  exp_drops = 0;
  bit  mon_en    = 1'b0;

  function automatic logic [DW-1:0] exp_status(input int cnt);
    int v;
    v = cnt * 4 + ((cnt == DEPTH) ? 2 : 0) + ((cnt == 0) ? 1 : 0);
    return DW'(v);
  endfunction

  // Stream scoreboard: head word, valid and ordering against the model queue.
  always @(negedge pclk) begin
    if (mon_en) begin
      n_checks++;
      if (bus.m_valid !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL stream_valid got %0b exp %0b", bus.m_valid, exp_q.size() != 0);
      end else if (bus.m_valid) begin
        n_checks++;
        if (bus.m_data !== exp_q[0]) begin
          n_fail++;
          $display("FAIL stream_data got %h exp %h", bus.m_data, exp_q[0]);
        end
        if (bus.m_ready === 1'b1) void'(exp_q.pop_front());
      end else begin
        n_checks++;
        if (bus.m_data !== '0) begin
          n_fail++;
          $display("FAIL stream_data_idle got %h exp 0", bus.m_data);
        end
      end
    end
  end

  // One APB transfer starting at posedge+1; returns at posedge+1 after completion.
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          output logic [DW-1:0] rdata, output logic err, output int waits);
    bit done;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = data;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    waits = 0; rdata = '0; err = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge pclk);
      if (bus.pready === 1'b1) begin
        rdata = bus.prdata; err = bus.pslverr; done = 1'b1;
      end else begin
        waits++;
        if (waits > TMO) done = 1'b1;
        else @(posedge pclk);
      end
    end
    if (waits > TMO) begin
      n_checks++; n_fail++;
      $display("FAIL apb_timeout addr=%0h got no pready exp pready within %0d", addr, TMO);
    end
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic drain();
    ready_tb = 1'b1;
    for (int i = 0; i < TMO && exp_q.size() != 0; i++) @(posedge pclk);
    #1;
    ready_tb = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout got %0d left exp 0", exp_q.size());
    end
  endtask

  task automatic fill(input bit seq);
    logic [DW-1:0] rd; logic err; int w; logic [DW-1:0] d;
    for (int v = 1; v <= DEPTH; v++) begin
      d = seq ? DW'(v) : DW'($urandom);
      apb_xfer(1'b1, 4'h0, d, rd, err, w);
      if (!err) exp_q.push_back(d);
      n_checks++;
      if (err !== 1'b0 || w != 0) begin
        n_fail++;
        $display("FAIL fill_write got err=%0b waits=%0d exp err=0 waits=0", err, w);
      end
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] rd; logic err; int w;
    #2;
    n_checks++;
    if ({bus.pready, bus.pslverr, bus.prdata, bus.m_valid, bus.m_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%0b err=%0b rd=%h v=%0b d=%h exp all 0",
               bus.pready, bus.pslverr, bus.prdata, bus.m_valid, bus.m_data);
    end
    @(posedge pclk); #1;
    prst = 1'b0; mon_en = 1'b1;
    @(posedge pclk); #1;
    apb_xfer(1'b0, 4'h1, '0, rd, err, w);
    n_checks++;
    if (rd !== exp_status(0) || err !== 1'b0 || w != 0) begin
      n_fail++;
      $display("FAIL reset_status got %h err=%0b exp %h err=0", rd, err, exp_status(0));
    end
  endtask

  task automatic test_single_write();
    logic [DW-1:0] rd; logic err; int w;
    apb_xfer(1'b1, 4'h0, 17'h1ABCD, rd, err, w);
    exp_q.push_back(17'h1ABCD);
    n_checks++;
    if (err !== 1'b0 || w != 0) begin
      n_fail++;
      $display("FAIL single_write got err=%0b waits=%0d exp err=0 waits=0", err, w);
    end
    @(negedge pclk);
    n_checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 17'h1ABCD) begin
      n_fail++;
      $display("FAIL single_latency got v=%0b d=%h exp v=1 d=1abcd", bus.m_valid, bus.m_data);
    end
    @(posedge pclk); #1;
    apb_xfer(1'b0, 4'h1, '0, rd, err, w);
    n_checks++;
    if (rd !== exp_status(1) || err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_status got %h exp %h", rd, exp_status(1));
    end
    drain();
  endtask

  task automatic test_fill_stall();
    logic [DW-1:0] rd; logic err; int w;
    fill(1'b1);
    apb_xfer(1'b0, 4'h1, '0, rd, err, w);
    n_checks++;
    if (rd !== exp_status(DEPTH)) begin
      n_fail++;
      $display("FAIL full_status got %h exp %h", rd, exp_status(DEPTH));
    end
    fork
      apb_xfer(1'b1, 4'h0, DW'(16), rd, err, w);
      begin
        repeat (5) @(posedge pclk);
        #1 ready_tb = 1'b1;
        @(posedge pclk);
        #1 ready_tb = 1'b0;
      end
    join
    if (!err) exp_q.push_back(DW'(16));
    n_checks++;
    if (err !== 1'b0 || w != 5) begin
      n_fail++;
      $display("FAIL stall_release got err=%0b waits=%0d exp err=0 waits=5", err, w);
    end
    drain();
  endtask

  task automatic test_drop();
    logic [DW-1:0] rd; logic err; int w;
    fill(1'b0);
    apb_xfer(1'b1, 4'h0, 17'h00055, rd, err, w);
    exp_drops++;
    n_checks++;
    if (err !== 1'b1 || w != WLIM) begin
      n_fail++;
      $display("FAIL drop_resp got err=%0b waits=%0d exp err=1 waits=%0d", err, w, WLIM);
    end
    apb_xfer(1'b0, 4'h2, '0, rd, err, w);
    n_checks++;
    if (rd !== DW'(exp_drops) || err !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_count got %0d exp %0d", rd, exp_drops);
    end
    apb_xfer(1'b0, 4'h1, '0, rd, err, w);
    n_checks++;
    if (rd !== exp_status(DEPTH)) begin
      n_fail++;
      $display("FAIL drop_status got %h exp %h", rd, exp_status(DEPTH));
    end
  endtask

  task automatic test_errors();
    logic [DW-1:0] rd; logic err; int w; logic [AW-1:0] a; logic wr;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin wr = 1'b0; a = 4'h0; end
        1: begin wr = 1'b1; a = 4'h5; end
        2: begin wr = 1'b1; a = 4'h1; end
        default: begin wr = 1'($urandom_range(0, 1)); a = AW'($urandom_range(3, 15)); end
      endcase
      apb_xfer(wr, a, DW'($urandom), rd, err, w);
      n_checks++;
      if (err !== 1'b1 || rd !== '0 || w != 0) begin
        n_fail++;
        $display("FAIL err_access a=%0h wr=%0b got err=%0b rd=%h waits=%0d exp err=1 rd=0 waits=0",
                 a, wr, err, rd, w);
      end
    end
    apb_xfer(1'b0, 4'h1, '0, rd, err, w);
    n_checks++;
    if (rd !== exp_status(exp_q.size())) begin
      n_fail++;
      $display("FAIL err_status got %h exp %h", rd, exp_status(exp_q.size()));
    end
    apb_xfer(1'b1, 4'h2, DW'($urandom), rd, err, w);
    exp_drops = 0;
    n_checks++;
    if (err !== 1'b0 || w != 0) begin
      n_fail++;
      $display("FAIL drops_clear_wr got err=%0b exp 0", err);
    end
    apb_xfer(1'b0, 4'h2, '0, rd, err, w);
    n_checks++;
    if (rd !== DW'(exp_drops) || err !== 1'b0) begin
      n_fail++;
      $display("FAIL drops_cleared got %0d exp %0d", rd, exp_drops);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd; logic err; int w; logic [DW-1:0] d;
    ready_tb = 1'b1;
    for (int k = 0; k < 20; k++) begin
      d = DW'($urandom);
      apb_xfer(1'b1, 4'h0, d, rd, err, w);
      if (!err) exp_q.push_back(d);
      n_checks++;
      if (err !== 1'b0 || w != 0) begin
        n_fail++;
        $display("FAIL b2b_write k=%0d got err=%0b waits=%0d exp 0/0", k, err, w);
      end
    end
    drain();
    apb_xfer(1'b0, 4'h1, '0, rd, err, w);
    n_checks++;
    if (rd !== exp_status(0)) begin
      n_fail++;
      $display("FAIL b2b_status got %h exp %h", rd, exp_status(0));
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] rd; logic err; int w; logic [DW-1:0] d; int op;
    rand_en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        d = DW'($urandom);
        apb_xfer(1'b1, 4'h0, d, rd, err, w);
        if (!err) exp_q.push_back(d);
        else exp_drops++;
        n_checks++;
        if ((err === 1'b1 && w != WLIM) || (err === 1'b0 && w >= WLIM) || rd !== '0) begin
          n_fail++;
          $display("FAIL rand_write got err=%0b waits=%0d rd=%h exp consistent", err, w, rd);
        end
      end else if (op <= 7) begin
        apb_xfer(1'b0, 4'h2, '0, rd, err, w);
        n_checks++;
        if (rd !== DW'(exp_drops) || err !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_drops got %0d exp %0d", rd, exp_drops);
        end
      end else if (op == 8) begin
        apb_xfer(1'($urandom_range(0, 1)), AW'($urandom_range(3, 15)), DW'($urandom), rd, err, w);
        n_checks++;
        if (err !== 1'b1 || rd !== '0 || w != 0) begin
          n_fail++;
          $display("FAIL rand_err got err=%0b rd=%h exp err=1 rd=0", err, rd);
        end
      end else begin
        rand_en = 1'b0;
        apb_xfer(1'b0, 4'h1, '0, rd, err, w);
        n_checks++;
        if (rd !== exp_status(exp_q.size())) begin
          n_fail++;
          $display("FAIL rand_status got %h exp %h", rd, exp_status(exp_q.size()));
        end
        rand_en = 1'b1;
      end
    end
    rand_en = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_wait();
    logic [DW-1:0] rd; logic err; int w;
    fill(1'b0);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 4'h0; bus.pwdata = 17'h0AAAA;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    repeat (3) @(posedge pclk);
    mon_en = 1'b0;
    #2 prst = 1'b1;
    #1;
    n_checks++;
    if ({bus.pready, bus.pslverr, bus.prdata, bus.m_valid, bus.m_data} !== '0) begin
      n_fail++;
      $display("FAIL midwait_reset got rdy=%0b err=%0b rd=%h v=%0b d=%h exp all 0",
               bus.pready, bus.pslverr, bus.prdata, bus.m_valid, bus.m_data);
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
    exp_q.delete();
    exp_drops = 0;
    @(posedge pclk); #1;
    prst = 1'b0; mon_en = 1'b1;
    repeat (WLIM + 4) @(posedge pclk);
    #1;
    apb_xfer(1'b0, 4'h1, '0, rd, err, w);
    n_checks++;
    if (rd !== exp_status(0)) begin
      n_fail++;
      $display("FAIL midwait_status got %h exp %h", rd, exp_status(0));
    end
    apb_xfer(1'b0, 4'h2, '0, rd, err, w);
    n_checks++;
    if (rd !== '0) begin
      n_fail++;
      $display("FAIL midwait_drops got %0d exp 0", rd);
    end
  endtask

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    test_reset();
    test_single_write();
    test_fill_stall();
    test_drop();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    repeat (2) @(posedge pclk);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish exp finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
